// File: rtl/quad_gate_golden_ref.sv
// quad_gate_golden_ref: selectable 4-input gate with registered output and 16-pattern truth-table sweep.
// Define GATE_EXT_EN to enable OR/NOR/XOR/XNOR; otherwise only AND and NAND exist.
module quad_gate_golden_ref #(
    parameter logic RSV_VAL   = 1'b0,
    parameter int   SWEEP_LEN = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  pattern,
    input  logic [2:0]  gate_sel,
    output logic        y,
    output logic        y_q,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] golden,
    output logic        sel_err
);
    typedef enum logic {IDLE, SWEEP} state_t;

    state_t      r_state;
    logic [2:0]  r_sel;
    logic [3:0]  r_idx;
    logic        r_y_q;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_golden;
    logic        r_sel_err;
    logic        w_y;

    function automatic logic f_rsv(input logic [2:0] s);
`ifdef GATE_EXT_EN
        return s[2] & s[1];
`else
        return !(s == 3'b000 || s == 3'b010);
`endif
    endfunction

    function automatic logic f_eval(input logic [2:0] s, input logic [3:0] p);
`ifdef GATE_EXT_EN
        return f_rsv(s)      ? RSV_VAL :
               s == 3'b000   ? &p  :
               s == 3'b001   ? |p  :
               s == 3'b010   ? ~&p :
               s == 3'b011   ? ~|p :
               s == 3'b100   ? ^p  : ~^p;
`else
        return f_rsv(s) ? RSV_VAL : (s[1] ? ~&p : &p);
`endif
    endfunction

    assign w_y     = f_eval(gate_sel, pattern);
    assign y       = w_y;
    assign y_q     = r_y_q;
    assign busy    = r_busy;
    assign done    = r_done;
    assign golden  = r_golden;
    assign sel_err = r_sel_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sel     <= 3'b000;
            r_idx     <= 4'd0;
            r_y_q     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_golden  <= 16'h0000;
            r_sel_err <= 1'b0;
        end else begin
            r_y_q <= w_y;
            if (r_state == IDLE) begin
                r_done    <= 1'b0;
                r_sel_err <= f_rsv(gate_sel);
                if (start) begin
                    r_sel    <= gate_sel;
                    r_golden <= 16'h0000;
                    r_idx    <= 4'd0;
                    r_busy   <= 1'b1;
                    r_state  <= SWEEP;
                end
            end else begin
                r_golden[r_idx] <= f_eval(r_sel, r_idx);
                r_idx           <= r_idx + 4'd1;
                r_sel_err       <= f_rsv(r_sel);
                // Last pattern: hand sel_err back to the live select as we go idle
                if (r_idx == 4'(SWEEP_LEN - 1)) begin
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_state   <= IDLE;
                    r_sel_err <= f_rsv(gate_sel);
                end
            end
        end
    end
endmodule

// File: tb/tb_quad_gate_golden_ref.sv
// tb_quad_gate_golden_ref: table-driven gate checks plus scoreboarded sweeps for quad_gate_golden_ref.
module tb_quad_gate_golden_ref;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  pattern = 4'd0;
    logic [2:0]  gate_sel = 3'd0;
    logic        start = 1'b0;
    logic        y, y_q, busy, done, sel_err;
    logic [15:0] golden;

    int n_pass = 0;
    int n_total = 0;
    logic        q_y[$];
    logic [15:0] q_g[$];

`ifdef GATE_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    typedef struct {
        logic [2:0] sel;
        logic [3:0] pat;
        logic       y_ext;
        logic       e_ext;
        logic       y_base;
        logic       e_base;
    } vec_t;

    vec_t vecs[12];

    quad_gate_golden_ref dut (
        .clk(clk), .rst(rst), .pattern(pattern), .gate_sel(gate_sel),
        .y(y), .y_q(y_q), .start(start), .busy(busy), .done(done),
        .golden(golden), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic sweep(input logic [2:0] sel, input logic [15:0] exp_g, input logic exp_err, input int disturb);
        int n;
        int dones;
        logic [15:0] eg;
        n = 0;
        dones = 0;
        @(negedge clk);
        gate_sel = sel;
        start = 1'b1;
        q_g.push_back(exp_g);
        @(posedge clk); #1;
        chk("sweep_busy_start", 16'(busy), 16'd1);
        chk("sweep_sel_err", 16'(sel_err), 16'(exp_err));
        for (int c = 1; c <= 40 && n == 0; c++) begin
            @(negedge clk);
            start = (c == disturb);
            if (c == disturb) gate_sel = 3'b010;
            @(posedge clk); #1;
            if (done) begin
                n = c;
                dones++;
            end
        end
        start = 1'b0;
        chk("sweep_len", 16'(n), 16'd16);
        eg = q_g.pop_front();
        chk("sweep_golden", golden, eg);
        chk("sweep_busy_end", 16'(busy), 16'd0);
        @(posedge clk); #1;
        if (done) dones++;
        chk("done_pulses", 16'(dones), 16'd1);
        chk("golden_hold", golden, eg);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 4'b1111, 1, 0, 1, 0};
        vecs[1]  = '{3'b000, 4'b1110, 0, 0, 0, 0};
        vecs[2]  = '{3'b010, 4'b1111, 0, 0, 0, 0};
        vecs[3]  = '{3'b010, 4'b0000, 1, 0, 1, 0};
        vecs[4]  = '{3'b001, 4'b0000, 0, 0, 0, 1};
        vecs[5]  = '{3'b001, 4'b0100, 1, 0, 0, 1};
        vecs[6]  = '{3'b011, 4'b0000, 1, 0, 0, 1};
        vecs[7]  = '{3'b100, 4'b0111, 1, 0, 0, 1};
        vecs[8]  = '{3'b100, 4'b0110, 0, 0, 0, 1};
        vecs[9]  = '{3'b101, 4'b0110, 1, 0, 0, 1};
        vecs[10] = '{3'b110, 4'b1111, 0, 1, 0, 1};
        vecs[11] = '{3'b111, 4'b0000, 0, 1, 0, 1};

        #12;
        chk("rst_y_q", 16'(y_q), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_golden", golden, 16'h0000);
        chk("rst_sel_err", 16'(sel_err), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            gate_sel = vecs[i].sel;
            pattern  = vecs[i].pat;
            q_y.push_back(EXT ? vecs[i].y_ext : vecs[i].y_base);
            #1;
            chk($sformatf("y_%0d", i), 16'(y), 16'(EXT ? vecs[i].y_ext : vecs[i].y_base));
            @(posedge clk); #1;
            chk($sformatf("y_q_%0d", i), 16'(y_q), 16'(q_y.pop_front()));
            chk($sformatf("sel_err_%0d", i), 16'(sel_err), 16'(EXT ? vecs[i].e_ext : vecs[i].e_base));
        end

        sweep(3'b000, 16'h8000, 1'b0, 0);
        sweep(3'b010, 16'h7FFF, 1'b0, 0);
        if (EXT) begin
            sweep(3'b001, 16'hFFFE, 1'b0, 0);
            sweep(3'b011, 16'h0001, 1'b0, 0);
            sweep(3'b100, 16'h6996, 1'b0, 0);
            sweep(3'b101, 16'h9669, 1'b0, 0);
        end else begin
            sweep(3'b100, 16'h0000, 1'b1, 0);
        end
        sweep(3'b000, 16'h8000, 1'b0, 5);
        sweep(3'b110, 16'h0000, 1'b1, 0);

        @(negedge clk);
        gate_sel = 3'b000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy", 16'(busy), 16'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_golden", golden, 16'h0000);
        chk("abort_done", 16'(done), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int stray = 0;
            repeat (20) begin
                @(posedge clk); #1;
                if (done || busy) stray++;
            end
            chk("abort_no_done", 16'(stray), 16'd0);
        end
        sweep(3'b000, 16'h8000, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
